// File: rtl/seq_lock_pkg.sv
// Shared state encoding and helpers for the serial combination lock.
package seq_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_PROGRAM  = 3'd3,
      ST_LOCKOUT  = 3'd4
   } lock_state_e;

   // Seven-segment decoder code for a state; equals the state encoding.
   function automatic logic [2:0] state_to_code(input lock_state_e s);
      return s;
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_tick_timer.sv
// Loadable down-counter shared by all timed lock states.
module lock_tick_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_100Mhz,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load has priority over a coincident tick; counting stops at zero.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (tick && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/seq_lock_prog.sv
// Serial combination lock with run-time programmable code, failed-attempt
// lockout, inter-digit timeout and auto-relock.
module seq_lock_prog
   import seq_lock_pkg::*;
#(
   parameter int unsigned           CODE_LEN      = 6,
   parameter logic [CODE_LEN-1:0]   DEFAULT_CODE  = 6'b010111,
   parameter int unsigned           MAX_FAIL      = 3,
   parameter int unsigned           TIMEOUT_TICKS = 4,
   parameter int unsigned           LOCKOUT_TICKS = 8,
   parameter int unsigned           UNLOCK_TICKS  = 5
) (
   input  logic                              clk_100Mhz,
   input  logic                              reset,
   input  logic                              tick,
   input  logic                              pulse_zero,
   input  logic                              pulse_one,
   input  logic                              prog_req,
   input  logic                              lock_cmd,
   output logic                              unlocked,
   output logic                              lockout,
   output logic                              fail_pulse,
   output logic                              prog_done,
   output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
   output logic [2:0]                        state_code
);

   localparam int unsigned DW = $clog2(CODE_LEN + 1);
   localparam int unsigned FW = $clog2(MAX_FAIL + 1);
   localparam int unsigned TW = $clog2(max3(TIMEOUT_TICKS, LOCKOUT_TICKS, UNLOCK_TICKS)) + 1;

   localparam logic [DW-1:0] CNT_FULL   = DW'(CODE_LEN);
   localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
   localparam logic [TW-1:0] T_TIMEOUT  = TW'(TIMEOUT_TICKS);
   localparam logic [TW-1:0] T_LOCKOUT  = TW'(LOCKOUT_TICKS);
   localparam logic [TW-1:0] T_UNLOCK   = TW'(UNLOCK_TICKS);

   lock_state_e          state, state_nxt;
   logic [CODE_LEN-1:0]  sr, sr_nxt;
   logic [CODE_LEN-1:0]  code, code_nxt;
   logic [DW-1:0]        dcnt_nxt, dcnt_inc;
   logic [FW-1:0]        fcnt_nxt, fcnt_inc;
   logic                 cmp_q, cmp_nxt;
   logic                 match_q, match_nxt;
   logic                 fail_nxt, done_nxt;
   logic                 tmr_load, tmr_zero;
   logic [TW-1:0]        tmr_val;
   logic                 digit_valid;
   logic [CODE_LEN-1:0]  shifted;

   assign digit_valid = pulse_zero ^ pulse_one;
   assign shifted     = {sr[CODE_LEN-2:0], pulse_one};
   assign dcnt_inc    = digit_cnt + 1'b1;
   assign fcnt_inc    = fail_cnt + 1'b1;

   lock_tick_timer #(.WIDTH(TW)) u_timer (
      .clk_100Mhz (clk_100Mhz),
      .reset      (reset),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .tick       (tick),
      .zero       (tmr_zero)
   );

   // State and datapath registers; the code register returns to default on reset.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         sr         <= '0;
         code       <= DEFAULT_CODE;
         digit_cnt  <= '0;
         fail_cnt   <= '0;
         cmp_q      <= 1'b0;
         match_q    <= 1'b0;
         fail_pulse <= 1'b0;
         prog_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         sr         <= sr_nxt;
         code       <= code_nxt;
         digit_cnt  <= dcnt_nxt;
         fail_cnt   <= fcnt_nxt;
         cmp_q      <= cmp_nxt;
         match_q    <= match_nxt;
         fail_pulse <= fail_nxt;
         prog_done  <= done_nxt;
      end
   end

   // Next-state and datapath control. A full attempt spends one cycle
   // registering the comparison and one acting on it, so unlocked rises
   // two edges after the last digit; digits in that window are dropped.
   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      code_nxt  = code;
      dcnt_nxt  = digit_cnt;
      fcnt_nxt  = fail_cnt;
      cmp_nxt   = 1'b0;
      match_nxt = match_q;
      fail_nxt  = 1'b0;
      done_nxt  = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_IDLE: begin
            if (digit_valid) begin
               state_nxt = ST_ENTRY;
               sr_nxt    = shifted;
               dcnt_nxt  = DW'(1);
               tmr_load  = 1'b1;
               tmr_val   = T_TIMEOUT;
            end
         end
         ST_ENTRY: begin
            if (cmp_q) begin
               dcnt_nxt = '0;
               if (match_q) begin
                  state_nxt = ST_UNLOCKED;
                  fcnt_nxt  = '0;
                  tmr_load  = 1'b1;
                  tmr_val   = T_UNLOCK;
               end else begin
                  fail_nxt = 1'b1;
                  fcnt_nxt = fcnt_inc;
                  if (fcnt_inc == FAIL_LIMIT) begin
                     state_nxt = ST_LOCKOUT;
                     tmr_load  = 1'b1;
                     tmr_val   = T_LOCKOUT;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end else if (digit_cnt == CNT_FULL) begin
               cmp_nxt   = 1'b1;
               match_nxt = (sr == code);
            end else if (digit_valid) begin
               sr_nxt   = shifted;
               dcnt_nxt = dcnt_inc;
               tmr_load = 1'b1;
               tmr_val  = T_TIMEOUT;
            end else if (tmr_zero) begin
               state_nxt = ST_IDLE;
               dcnt_nxt  = '0;
            end
         end
         ST_UNLOCKED: begin
            if (lock_cmd) begin
               state_nxt = ST_IDLE;
            end else if (prog_req) begin
               state_nxt = ST_PROGRAM;
               dcnt_nxt  = '0;
               tmr_load  = 1'b1;
               tmr_val   = T_TIMEOUT;
            end else if (tmr_zero) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_PROGRAM: begin
            if (lock_cmd) begin
               state_nxt = ST_IDLE;
               dcnt_nxt  = '0;
            end else if (digit_cnt == CNT_FULL) begin
               code_nxt  = sr;
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
               dcnt_nxt  = '0;
            end else if (digit_valid) begin
               sr_nxt   = shifted;
               dcnt_nxt = dcnt_inc;
               tmr_load = 1'b1;
               tmr_val  = T_TIMEOUT;
            end else if (tmr_zero) begin
               state_nxt = ST_IDLE;
               dcnt_nxt  = '0;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_zero) begin
               state_nxt = ST_IDLE;
               fcnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            dcnt_nxt  = '0;
         end
      endcase
   end

   assign unlocked   = (state == ST_UNLOCKED);
   assign lockout    = (state == ST_LOCKOUT);
   assign state_code = state_to_code(state);

endmodule

// File: tb/tb_seq_lock_prog.sv
// Directed self-checking bench for seq_lock_prog at default parameters, tick held high.
module tb_seq_lock_prog;

   logic       clk_100Mhz = 1'b0;
   logic       reset      = 1'b0;
   logic       tick       = 1'b1;
   logic       pulse_zero = 1'b0;
   logic       pulse_one  = 1'b0;
   logic       prog_req   = 1'b0;
   logic       lock_cmd   = 1'b0;
   logic       unlocked, lockout, fail_pulse, prog_done;
   logic [2:0] digit_cnt;
   logic [1:0] fail_cnt;
   logic [2:0] state_code;

   int n_cmp = 0;
   int n_err = 0;

   seq_lock_prog dut (
      .clk_100Mhz (clk_100Mhz),
      .reset      (reset),
      .tick       (tick),
      .pulse_zero (pulse_zero),
      .pulse_one  (pulse_one),
      .prog_req   (prog_req),
      .lock_cmd   (lock_cmd),
      .unlocked   (unlocked),
      .lockout    (lockout),
      .fail_pulse (fail_pulse),
      .prog_done  (prog_done),
      .digit_cnt  (digit_cnt),
      .fail_cnt   (fail_cnt),
      .state_code (state_code)
   );

   always #5 clk_100Mhz = ~clk_100Mhz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the digit is sampled on the next posedge.
   task automatic send_digit(input logic b);
      pulse_zero = ~b;
      pulse_one  = b;
      @(negedge clk_100Mhz);
      pulse_zero = 1'b0;
      pulse_one  = 1'b0;
   endtask

   task automatic send_code(input logic [5:0] c);
      for (int i = 5; i >= 0; i--) send_digit(c[i]);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_100Mhz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cycles(3);
      check("rst_unlocked", unlocked, 0);
      check("rst_state", state_code, 0);
      check("rst_dcnt", digit_cnt, 0);
      reset = 1'b1;
      wait_cycles(2);

      // correct default code unlocks two edges after the last digit
      send_code(6'b010111);
      check("t1_dcnt_full", digit_cnt, 6);
      wait_cycles(1);
      check("t1_not_yet", unlocked, 0);
      wait_cycles(1);
      check("t1_unlocked", unlocked, 1);
      check("t1_state", state_code, 2);
      check("t1_fcnt", fail_cnt, 0);
      wait_cycles(5);
      check("t1_still_unl", unlocked, 1);
      wait_cycles(1);
      check("t1_relock", unlocked, 0);
      check("t1_relock_st", state_code, 0);

      // three wrong attempts lead to lockout
      for (int k = 1; k <= 3; k++) begin
         send_code(6'b111111);
         wait_cycles(1);
         check("t2_nofail_yet", fail_pulse, 0);
         wait_cycles(1);
         check("t2_fail_pulse", fail_pulse, 1);
         check("t2_fcnt", fail_cnt, k);
         check("t2_state", state_code, (k == 3) ? 4 : 0);
         wait_cycles(1);
         check("t2_pulse_end", fail_pulse, 0);
      end
      check("t2_lockout", lockout, 1);
      send_code(6'b010111);
      check("t2_ign_dcnt", digit_cnt, 0);
      check("t2_ign_unl", unlocked, 0);
      wait_cycles(1);
      check("t2_lock_last", lockout, 1);
      wait_cycles(1);
      check("t2_lock_end", lockout, 0);
      check("t2_fcnt_clr", fail_cnt, 0);
      check("t2_idle", state_code, 0);

      // partial entry abandoned by timeout
      send_code(6'b000000 | 6'b0);
      wait_cycles(8);
      check("t3_pre_idle", state_code, 0);
      send_digit(1'b0); send_digit(1'b1); send_digit(1'b0);
      check("t3_dcnt3", digit_cnt, 3);
      wait_cycles(4);
      check("t3_still_entry", state_code, 1);
      wait_cycles(1);
      check("t3_timeout_st", state_code, 0);
      check("t3_timeout_dcnt", digit_cnt, 0);
      check("t3_fcnt", fail_cnt, 1);
      send_code(6'b010111);
      wait_cycles(2);
      check("t3_unlock", unlocked, 1);
      check("t3_fcnt_clr", fail_cnt, 0);

      // reprogram the code
      prog_req = 1'b1;
      @(negedge clk_100Mhz);
      prog_req = 1'b0;
      check("t4_program", state_code, 3);
      send_code(6'b110010);
      check("t4_dcnt", digit_cnt, 6);
      wait_cycles(1);
      check("t4_done", prog_done, 1);
      check("t4_idle", state_code, 0);
      wait_cycles(1);
      check("t4_done_end", prog_done, 0);
      send_code(6'b010111);
      wait_cycles(2);
      check("t4_old_fails", fail_pulse, 1);
      check("t4_old_unl", unlocked, 0);
      send_code(6'b110010);
      wait_cycles(2);
      check("t4_new_unl", unlocked, 1);
      lock_cmd = 1'b1;
      prog_req = 1'b1;
      @(negedge clk_100Mhz);
      lock_cmd = 1'b0;
      prog_req = 1'b0;
      check("t4_lock_wins", state_code, 0);

      // simultaneous pulses ignored; reset mid-entry restores defaults
      send_code(6'b111111);
      wait_cycles(2);
      check("t5_fcnt1", fail_cnt, 1);
      send_digit(1'b1); send_digit(1'b0);
      pulse_zero = 1'b1;
      pulse_one  = 1'b1;
      @(negedge clk_100Mhz);
      pulse_zero = 1'b0;
      pulse_one  = 1'b0;
      check("t5_both_ign", digit_cnt, 2);
      reset = 1'b0;
      #1;
      check("t5_rst_state", state_code, 0);
      check("t5_rst_dcnt", digit_cnt, 0);
      check("t5_rst_fcnt", fail_cnt, 0);
      @(negedge clk_100Mhz);
      reset = 1'b1;
      wait_cycles(1);
      send_code(6'b010111);
      wait_cycles(2);
      check("t5_default_code", unlocked, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
